// File: rtl/rfm_pkg.sv
// Shared definitions for the per-bank RFM issuer: FSM state encoding,
// default timing/threshold constants and a helper that sizes the gap timer.
package rfm_pkg;

   // Issuer FSM states (2-bit encoding)
   typedef enum logic [1:0] {
      RFM_ST_IDLE = 2'd0,
      RFM_ST_ACT  = 2'd1,
      RFM_ST_WAIT = 2'd2
   } rfm_state_e;

   // Default configuration values
   localparam int RFM_DEF_ADDR_SIZE     = 18;
   localparam int RFM_DEF_RAA_BITS      = 8;
   localparam int RFM_DEF_RAAIMT        = 8;
   localparam int RFM_DEF_RAAMMT        = 24;
   localparam int RFM_DEF_T_ACT         = 5;
   localparam int RFM_DEF_T_RFM         = 8;
   localparam int RFM_DEF_T_NRR_TIMEOUT = 64;

   // Width of a down-counter able to hold the longest interval plus one bit
   function automatic int rfm_timer_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end
      if (c > m) begin
         m = c;
      end
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/rfm_gap_timer.sv
// Loadable down-counter with a zero flag. The issuer loads it when it leaves
// IDLE and watches zero_o to know when the ACT gap or WAIT interval is over.
// A load takes priority; otherwise the count decrements until it reaches zero
// and then holds there.
module rfm_gap_timer #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load, decrement, or hold at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rfm_issuer_bank.sv
// Controller-side per-bank RFM issuer. Forwards scheduler ACTs with a minimum
// spacing of T_ACT, keeps the rolling accumulated ACT count (RAA), issues RFM
// opportunistically at RAAIMT and mandatorily at RAAMMT, and records the
// NRR address returned by the DRAM-side tracker.
//
// Optional feature macro: RFM_ISSUER_NRR_WAIT_EN
//   defined   - WAIT ends on nrr_cmd or after T_NRR_TIMEOUT (nrr_timeout pulse)
//   undefined - WAIT is a fixed T_RFM interval, nrr_timeout tied low
//
// Timing parameters must satisfy T_ACT >= 2, T_RFM >= 2, T_NRR_TIMEOUT >= 1,
// and RAAIMT <= RAAMMT < 2**RAA_BITS.
module rfm_issuer_bank
   import rfm_pkg::*;
#(
   parameter int ADDR_SIZE     = RFM_DEF_ADDR_SIZE,
   parameter int RAA_BITS      = RFM_DEF_RAA_BITS,
   parameter int RAAIMT        = RFM_DEF_RAAIMT,
   parameter int RAAMMT        = RFM_DEF_RAAMMT,
   parameter int T_ACT         = RFM_DEF_T_ACT,
   parameter int T_RFM         = RFM_DEF_T_RFM,
   parameter int T_NRR_TIMEOUT = RFM_DEF_T_NRR_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 req_valid,
   input  logic [ADDR_SIZE-1:0] req_addr,
   output logic                 req_ready,
   output logic                 act_cmd,
   output logic [ADDR_SIZE-1:0] act_addr,
   output logic                 rfm_cmd,
   input  logic                 ref_cmd,
   input  logic                 nrr_cmd,
   input  logic [ADDR_SIZE-1:0] nrr_addr,
   output logic [ADDR_SIZE-1:0] last_nrr_addr,
   output logic [RAA_BITS-1:0]  raa_cnt,
   output logic                 busy,
   output logic                 nrr_timeout
);

   localparam int TW = rfm_timer_width(T_ACT, T_RFM, T_NRR_TIMEOUT);
   localparam int SW = RAA_BITS + 2;

   // The timer is loaded in the decision cycle and first seen one cycle
   // later, so an interval of T cycles back to IDLE needs a load of T-2.
   localparam logic [TW-1:0] LD_ACT = TW'(T_ACT - 2);
`ifdef RFM_ISSUER_NRR_WAIT_EN
   // Reaching zero marks the last WAIT cycle in which nrr_cmd can still
   // prevent the timeout pulse.
   localparam logic [TW-1:0] LD_WAIT = TW'(T_NRR_TIMEOUT - 1);
`else
   localparam logic [TW-1:0] LD_WAIT = TW'(T_RFM - 2);
`endif

   localparam logic [RAA_BITS-1:0] IMT_V = RAA_BITS'(RAAIMT);
   localparam logic [RAA_BITS-1:0] MMT_V = RAA_BITS'(RAAMMT);
   localparam logic signed [SW-1:0] IMT_S = SW'(RAAIMT);
   localparam logic signed [SW-1:0] ONE_S = SW'(1);
   localparam logic signed [SW-1:0] MAX_S = SW'((2 ** RAA_BITS) - 1);

   rfm_state_e state_q;
   rfm_state_e state_d;

   logic [RAA_BITS-1:0]  raa_q;
   logic [RAA_BITS-1:0]  raa_d;
   logic                 act_cmd_q;
   logic [ADDR_SIZE-1:0] act_addr_q;
   logic                 rfm_cmd_q;
   logic [ADDR_SIZE-1:0] last_nrr_q;

   logic                 req_ready_s;
   logic                 act_fire_s;
   logic                 rfm_fire_s;
   logic                 tmr_load_s;
   logic [TW-1:0]        tmr_val_s;
   logic                 tmr_zero_s;
   logic signed [SW-1:0] raa_sum_s;

`ifdef RFM_ISSUER_NRR_WAIT_EN
   logic nrr_timeout_q;
   logic nrr_timeout_d;
`endif

   assign req_ready_s = (state_q == RFM_ST_IDLE) && (raa_q < MMT_V);

   rfm_gap_timer #(
      .W (TW)
   ) u_gap_timer (
      .clk        (clk),
      .rstn       (rstn),
      .load_i     (tmr_load_s),
      .load_val_i (tmr_val_s),
      .zero_o     (tmr_zero_s)
   );

   // Next-state logic: IDLE arbitration between mandatory RFM, ACT and
   // opportunistic RFM; ACT and WAIT run until the gap timer expires
   always_comb begin
      state_d    = state_q;
      act_fire_s = 1'b0;
      rfm_fire_s = 1'b0;
      tmr_load_s = 1'b0;
      tmr_val_s  = '0;
`ifdef RFM_ISSUER_NRR_WAIT_EN
      nrr_timeout_d = 1'b0;
`endif
      case (state_q)
         RFM_ST_IDLE: begin
            if (raa_q >= MMT_V) begin
               rfm_fire_s = 1'b1;
            end else if (req_valid && req_ready_s) begin
               act_fire_s = 1'b1;
            end else if ((raa_q >= IMT_V) && !req_valid) begin
               rfm_fire_s = 1'b1;
            end else begin
               state_d = RFM_ST_IDLE;
            end
            if (act_fire_s) begin
               state_d    = RFM_ST_ACT;
               tmr_load_s = 1'b1;
               tmr_val_s  = LD_ACT;
            end else if (rfm_fire_s) begin
               state_d    = RFM_ST_WAIT;
               tmr_load_s = 1'b1;
               tmr_val_s  = LD_WAIT;
            end else begin
               tmr_load_s = 1'b0;
            end
         end
         RFM_ST_ACT: begin
            if (tmr_zero_s) begin
               state_d = RFM_ST_IDLE;
            end else begin
               state_d = RFM_ST_ACT;
            end
         end
         RFM_ST_WAIT: begin
`ifdef RFM_ISSUER_NRR_WAIT_EN
            // Timeout pulse cycle is the final WAIT cycle
            if (nrr_timeout_q) begin
               state_d = RFM_ST_IDLE;
            end else if (nrr_cmd) begin
               state_d = RFM_ST_IDLE;
            end else if (tmr_zero_s) begin
               nrr_timeout_d = 1'b1;
            end else begin
               state_d = RFM_ST_WAIT;
            end
`else
            if (tmr_zero_s) begin
               state_d = RFM_ST_IDLE;
            end else begin
               state_d = RFM_ST_WAIT;
            end
`endif
         end
         default: begin
            state_d = RFM_ST_IDLE;
         end
      endcase
   end

   // RAA update: all contributions in one signed sum, saturated to range
   always_comb begin
      raa_sum_s = $signed({2'b00, raa_q});
      if (act_fire_s) begin
         raa_sum_s = raa_sum_s + ONE_S;
      end else begin
         raa_sum_s = raa_sum_s;
      end
      if (rfm_fire_s) begin
         raa_sum_s = raa_sum_s - IMT_S;
      end else begin
         raa_sum_s = raa_sum_s;
      end
      if (ref_cmd) begin
         raa_sum_s = raa_sum_s - IMT_S;
      end else begin
         raa_sum_s = raa_sum_s;
      end
      if (raa_sum_s[SW-1]) begin
         raa_d = '0;
      end else if (raa_sum_s > MAX_S) begin
         raa_d = '1;
      end else begin
         raa_d = raa_sum_s[RAA_BITS-1:0];
      end
   end

   // State, RAA and registered command outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= RFM_ST_IDLE;
         raa_q      <= '0;
         act_cmd_q  <= 1'b0;
         act_addr_q <= '0;
         rfm_cmd_q  <= 1'b0;
         last_nrr_q <= '0;
      end else begin
         state_q    <= state_d;
         raa_q      <= raa_d;
         act_cmd_q  <= act_fire_s;
         act_addr_q <= act_fire_s ? req_addr : '0;
         rfm_cmd_q  <= rfm_fire_s;
         if (nrr_cmd) begin
            last_nrr_q <= nrr_addr;
         end
      end
   end

`ifdef RFM_ISSUER_NRR_WAIT_EN
   // Registered one-cycle NRR timeout pulse
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         nrr_timeout_q <= 1'b0;
      end else begin
         nrr_timeout_q <= nrr_timeout_d;
      end
   end

   assign nrr_timeout = nrr_timeout_q;
`else
   assign nrr_timeout = 1'b0;
`endif

   assign req_ready     = req_ready_s;
   assign act_cmd       = act_cmd_q;
   assign act_addr      = act_addr_q;
   assign rfm_cmd       = rfm_cmd_q;
   assign last_nrr_addr = last_nrr_q;
   assign raa_cnt       = raa_q;
   assign busy          = (state_q != RFM_ST_IDLE);

endmodule

// File: tb/tb_rfm_issuer_bank.sv
// Self-checking bench for rfm_issuer_bank. A time-based reference model
// (cycle at which the bank is free again, rolling RAA count) predicts every
// act_cmd/rfm_cmd event into a scoreboard queue; a monitor pops and compares
// whenever the DUT pulses a command, and checks the level outputs each cycle.
module tb_rfm_issuer_bank;

   localparam int AW   = 18;
   localparam int IMT  = 8;
   localparam int MMT  = 24;
   localparam int TACT = 5;
   localparam int TRFM = 8;
   localparam int TTO  = 64;
   localparam int RMAX = 255;
`ifdef RFM_ISSUER_NRR_WAIT_EN
   localparam int NDLY = 5;
`else
   localparam int NDLY = 3;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          req_valid = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic          ref_cmd = 1'b0;
   logic          nrr_cmd = 1'b0;
   logic [AW-1:0] nrr_addr = '0;
   logic          req_ready, act_cmd, rfm_cmd, busy, nrr_timeout;
   logic [AW-1:0] act_addr, last_nrr_addr;
   logic [7:0]    raa_cnt;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   typedef struct {
      bit            is_rfm;
      int            at;
      logic [AW-1:0] addr;
      int            raa;
   } ev_t;
   ev_t exp_q[$];

   // reference model state
   int            m_raa = 0;
   int            m_free_at = 0;
   int            m_exp_to = -1;
   int            m_rfm_cyc = -1000;
   int            m_rfm_n = 0;
   bit            m_in_wait = 1'b0;
   bit            m_after_rfm = 1'b0;
   logic [AW-1:0] m_last_nrr = '0;

   rfm_issuer_bank dut (
      .clk           (clk),
      .rstn          (rstn),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_ready     (req_ready),
      .act_cmd       (act_cmd),
      .act_addr      (act_addr),
      .rfm_cmd       (rfm_cmd),
      .ref_cmd       (ref_cmd),
      .nrr_cmd       (nrr_cmd),
      .nrr_addr      (nrr_addr),
      .last_nrr_addr (last_nrr_addr),
      .raa_cnt       (raa_cnt),
      .busy          (busy),
      .nrr_timeout   (nrr_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
      end
   endtask

   task automatic bound_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s cyc=%0d got=bound_expired want=condition_reached", name, cyc);
   endtask

   // Model of one decision cycle 'cyc' with the inputs the DUT samples at its end
   function automatic void model_update(input bit v, input logic [AW-1:0] a, input bit r,
                                        input bit n, input logic [AW-1:0] na);
      bit idle;
      bit act;
      bit rfm;
      int nr;
      idle = (cyc >= m_free_at);
      act  = 1'b0;
      rfm  = 1'b0;
      if (n) m_last_nrr = na;
`ifdef RFM_ISSUER_NRR_WAIT_EN
      if (!idle && m_in_wait && n) begin
         m_free_at = cyc + 1;
         m_exp_to  = -1;
      end
`endif
      if (idle) begin
         m_in_wait = 1'b0;
         if (m_raa >= MMT) rfm = 1'b1;
         else if (v) act = 1'b1;
         else if (m_raa >= IMT) rfm = 1'b1;
      end
      nr = m_raa + (act ? 1 : 0) - (rfm ? IMT : 0) - (r ? IMT : 0);
      if (nr < 0) nr = 0;
      if (nr > RMAX) nr = RMAX;
      m_raa = nr;
      if (act) begin
         exp_q.push_back('{1'b0, cyc + 1, a, nr});
         m_free_at   = cyc + TACT;
         m_after_rfm = 1'b0;
      end
      if (rfm) begin
         exp_q.push_back('{1'b1, cyc + 1, '0, nr});
         m_rfm_cyc   = cyc + 1;
         m_rfm_n++;
         m_after_rfm = 1'b1;
         m_in_wait   = 1'b1;
`ifdef RFM_ISSUER_NRR_WAIT_EN
         m_free_at = cyc + TTO + 2;
         m_exp_to  = cyc + TTO + 1;
`else
         m_free_at = cyc + TRFM;
`endif
      end
   endfunction

   task automatic drive(input bit v, input logic [AW-1:0] a, input bit r,
                        input bit n, input logic [AW-1:0] na);
      req_valid = v;
      req_addr  = a;
      ref_cmd   = r;
      nrr_cmd   = n;
      nrr_addr  = na;
      model_update(v, a, r, n, na);
   endtask

   task automatic step(input bit v, input logic [AW-1:0] a, input bit r,
                       input bit n, input logic [AW-1:0] na);
      @(negedge clk);
      drive(v, a, r, n, na);
   endtask

   task automatic do_reset();
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = '0;
      ref_cmd   = 1'b0;
      nrr_cmd   = 1'b0;
      nrr_addr  = '0;
      rstn      = 1'b0;
      #1;
      chk("rst_act_cmd", act_cmd, 0);
      chk("rst_act_addr", act_addr, 0);
      chk("rst_rfm_cmd", rfm_cmd, 0);
      chk("rst_raa_cnt", raa_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_last_nrr", last_nrr_addr, 0);
      chk("rst_nrr_timeout", nrr_timeout, 0);
      m_raa       = 0;
      m_free_at   = 0;
      m_exp_to    = -1;
      m_rfm_cyc   = -1000;
      m_in_wait   = 1'b0;
      m_after_rfm = 1'b0;
      m_last_nrr  = '0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      model_update(1'b0, '0, 1'b0, 1'b0, '0);
   endtask

   // Monitor: level outputs every cycle, command pulses against the scoreboard
   initial begin : monitor
      bit  idle;
      ev_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rstn) begin
            idle = (cyc >= m_free_at);
            chk("raa_cnt", raa_cnt, m_raa);
            chk("req_ready", req_ready, idle && (m_raa < MMT));
            chk("busy", busy, !idle);
            chk("last_nrr_addr", last_nrr_addr, m_last_nrr);
`ifdef RFM_ISSUER_NRR_WAIT_EN
            chk("nrr_timeout", nrr_timeout, cyc == m_exp_to);
`else
            chk("nrr_timeout", nrr_timeout, 0);
`endif
            chk("act_rfm_excl", act_cmd & rfm_cmd, 0);
            if (!act_cmd) chk("act_addr_zero", act_addr, 0);
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
               e = exp_q.pop_front();
               total++;
               bad++;
               $display("FAIL missing_event cyc=%0d got=none want=%s_at_%0d",
                        cyc, e.is_rfm ? "rfm" : "act", e.at);
            end
            if (act_cmd || rfm_cmd) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_cmd cyc=%0d got=act%0d_rfm%0d want=none",
                           cyc, act_cmd, rfm_cmd);
               end else begin
                  e = exp_q.pop_front();
                  chk("cmd_cycle", cyc, e.at);
                  chk("cmd_is_rfm", rfm_cmd, e.is_rfm);
                  if (!e.is_rfm) chk("act_addr", act_addr, e.addr);
                  chk("cmd_raa", raa_cnt, e.raa);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1);
   end

   initial begin : stim
      bit r;
      int n;
      do_reset();

      // 8 ACTs with req_valid held, then drop: RFM follows, NRR mid-WAIT
      for (int i = 0; i < 200 && m_raa < 8; i++) step(1'b1, AW'($urandom), 1'b0, 1'b0, '0);
      if (m_raa < 8) bound_fail("t2_reach8");
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         drive(1'b0, '0, 1'b0, cyc == (m_rfm_cyc + NDLY), 18'h01234);
      end

      // REF at RAA 3 saturates to 0
      for (int i = 0; i < 200 && m_raa < 3; i++) step(1'b1, AW'($urandom), 1'b0, 1'b0, '0);
      if (m_raa < 3) bound_fail("t4_reach3");
      repeat (6) step(1'b0, '0, 1'b0, 1'b0, '0);
      step(1'b0, '0, 1'b1, 1'b0, '0);
      repeat (3) step(1'b0, '0, 1'b0, 1'b0, '0);

      // REF coincident with ACT at RAA 10 -> 3
      r = 1'b0;
      for (int i = 0; i < 300 && !r; i++) begin
         @(negedge clk);
         r = (m_raa == 10) && (cyc >= m_free_at);
         drive(1'b1, AW'($urandom), r, 1'b0, '0);
      end
      if (!r) bound_fail("t4_act_ref10");

      // req_valid held: mandatory RFM at 24 (first with coincident REF),
      // then reset while waiting after the second RFM at RAA 16
      n = m_rfm_n;
      r = 1'b0;
      for (int i = 0; i < 600 && !r; i++) begin
         @(negedge clk);
         if ((m_rfm_n >= n + 2) && (cyc < m_free_at) && m_after_rfm) begin
            r = 1'b1;
         end else begin
            drive(1'b1, AW'($urandom), (m_raa == 24) && (cyc >= m_free_at) && (m_rfm_n == n),
                  1'b0, '0);
         end
      end
      if (!r) bound_fail("t3_two_rfm");
      do_reset();

`ifdef RFM_ISSUER_NRR_WAIT_EN
      // RFM with no NRR: timeout pulse
      for (int i = 0; i < 200 && m_raa < 8; i++) step(1'b1, AW'($urandom), 1'b0, 1'b0, '0);
      repeat (90) step(1'b0, '0, 1'b0, 1'b0, '0);
`endif

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 9) < 7, AW'($urandom), $urandom_range(0, 29) == 0,
                 $urandom_range(0, 19) == 0, AW'($urandom));
         end
      end

      repeat (120) step(1'b0, '0, 1'b0, 1'b0, '0);
      @(posedge clk);
      #2;
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
